// File: rtl/mem_line_arbiter_if.sv
// Bundle of the icache, dcache and pmem line-transfer signals seen by the
// memory line arbiter. The slave modport is the arbiter's view: it receives
// cache requests and pmem responses, and it drives cache responses and pmem
// strobes. The master modport is the environment's view: the caches plus
// the memory / cacheline adaptor.
interface mem_line_arbiter_if #(
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [31:0]       i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [31:0]       d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Shares the single pmem port between icache line fills and dcache line
// fills/writebacks. One line transaction is granted at a time and is held
// until pmem responds. The D side wins ties, but once STARVE_LIMIT D grants
// have been issued back to back while I was waiting, the next grant goes to I.
module mem_line_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_W       = 256
) (
  input logic              clk,
  input logic              rst,
  mem_line_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [STREAK_W-1:0] streak;
  logic [31:0]         addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                write_q;
  logic                d_req;
  logic                grant_d;
  logic                grant_i;

  // Grant decision, only meaningful while IDLE; D wins unless I has been starved.
  always_comb begin
    d_req   = bus.d_read | bus.d_write;
    grant_d = (state == IDLE) && d_req && (!bus.i_read || (streak < STREAK_MAX));
    grant_i = (state == IDLE) && !grant_d && bus.i_read;
  end

  // Next state: every transaction returns to IDLE, so grants are never back to back.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = SERVE_D;
        else if (grant_i) state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the granted request so later requester-side changes cannot disturb pmem.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= bus.d_address;
      write_q <= bus.d_write;
      if (bus.d_write) wdata_q <= bus.d_wdata;
    end else if (grant_i) begin
      addr_q  <= bus.i_address;
      write_q <= 1'b0;
    end
  end

  // Count consecutive D grants made while I was waiting; any I grant clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!bus.i_read)              streak <= '0;
      else if (streak < STREAK_MAX) streak <= streak + STREAK_W'(1);
    end else if (grant_i) begin
      streak <= '0;
    end
  end

  // pmem strobes decode from state and the latched op, so they cannot glitch with inputs.
  assign bus.pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !write_q);
  assign bus.pmem_write   = (state == SERVE_D) && write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Completion pulses go only to the granted side; pmem_resp in IDLE is dropped.
  assign bus.i_resp  = (state == SERVE_I) && bus.pmem_resp;
  assign bus.d_resp  = (state == SERVE_D) && bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares the single physical memory port (pmem) between the instruction cache (read-only line fills) and the data cache (line fills and writebacks).
- Sits between both caches and the pmem/cacheline-adaptor boundary.
- Grants one line transaction at a time and holds the grant until pmem responds.
- D-side wins simultaneous requests, but a starvation guard keeps instruction fetch moving under heavy load/store traffic.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive D-side grants issued while an I-side request is pending; the next grant after this count goes to I.
- LINE_W, 256: cache line width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_read  in  1  icache line read request; held until i_resp
- i_address  in  32  icache line address, 32-byte aligned
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line writeback request
- d_address  in  32  dcache line address, 32-byte aligned
- d_wdata  in  LINE_W  writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  32  memory line address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset values:
  - state=IDLE, streak=0.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_resp=0, d_resp=0.
  - i_rdata and d_rdata are don't-care.
- IDLE, grant decision (evaluated each cycle):
  - D request pending (d_read|d_write) and (!i_read or streak<STARVE_LIMIT) -> SERVE_D.
  - Else if i_read -> SERVE_I.
  - Else stay in IDLE.
- Latch at grant edge:
  - Address and operation are latched into registers.
  - d_wdata is latched on D writes.
  - d_read&d_write together is illegal and is treated as a write.
- Streak counter, updated at grant:
  - D grant with i_read high: streak+1, saturating at STARVE_LIMIT.
  - D grant with i_read low: streak=0.
  - I grant: streak=0.
- Latency: a request first seen in IDLE at cycle t drives pmem_read or pmem_write from cycle t+1. The pmem strobe is a registered/state-decoded output, not combinational from requester inputs.
- SERVE_I / SERVE_D:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are held stable from the latched registers until pmem_resp.
  - Requester-side inputs changing mid-transaction have no effect.
- Completion:
  - On the pmem_resp cycle, the granted requester's resp is asserted combinationally that same cycle.
  - Its rdata = pmem_rdata, passed through.
  - The non-granted resp stays 0.
  - Next state = IDLE.
  - pmem strobes deassert from the next cycle.
- No back-to-back grant without IDLE:
  - There is a minimum of one IDLE cycle between transactions.
  - This guarantees the requester has consumed its resp and updated its request lines before re-arbitration.
- pmem_resp outside SERVE_* is ignored.
- Only one of pmem_read/pmem_write is high in any cycle.
- Reset mid-transaction:
  - Return to IDLE and drop strobes the next cycle.
  - No resp is issued for the aborted transaction.
  - A late pmem_resp after reset is ignored.
- Grant is not preemptible. A flush upstream does not abort an in-flight I fill; the fill completes and i_resp pulses normally.

Test Plan:
- Single I fill: i_read=1, i_address=0x0000_0060; pmem_resp after 5 cycles with pmem_rdata=A5..A5 -> pmem_read=1, pmem_address=0x60 from cycle t+1; i_resp one cycle with i_rdata=A5..A5; d_resp=0.
- Simultaneous request, streak=0: i_read and d_write (address 0x100, wdata=DEAD..) raised the same cycle -> D served first: pmem_write=1, addr 0x100, wdata DEAD..; after d_resp and one IDLE cycle, I served at 0x60.
- Starvation guard, STARVE_LIMIT=4: d_read continuously re-requested and i_read held high -> exactly 4 D grants, then an I grant; streak returns to 0 after the I grant.
- Input stability: during SERVE_D, change d_address to 0x200 and pulse d_write low -> pmem_address stays 0x100 and pmem_write stays 1 until pmem_resp.
- Reset mid-transaction: assert rst during SERVE_I, then deliver pmem_resp 2 cycles after reset -> all outputs 0 the cycle after rst; no i_resp pulse.
- Illegal d_read&d_write together -> pmem_write=1, pmem_read=0 for that transaction.
